// File: rtl/axis_width_conv_pkg.sv
// axis_width_conv_pkg: shared types and elaboration-time helpers for the
// N-bit to M-bit stream width converter (ping-pong LCM-bit regrouping).
package axis_width_conv_pkg;

    // Default geometry: 8-bit words in, 5-bit words out, 40-bit groups.
    localparam int DEF_N   = 8;
    localparam int DEF_M   = 5;
    localparam int DEF_LCM = 40;

    // Identifies one of the two regrouping banks.
    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_e;

    // Number of w-bit slots in an lcm-bit group.
    function automatic int slots(input int lcm, input int w);
        return lcm / w;
    endfunction

    // Width of an index counting 0..k-1; never narrower than one bit.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // True when lcm is a positive whole multiple of w.
    function automatic bit is_multiple(input int lcm, input int w);
        return (w > 0) && (lcm >= w) && ((lcm % w) == 0);
    endfunction

    // The bank a pointer moves to after finishing its current one.
    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/axis_width_conv.sv
// axis_width_conv: regroups a stream of N-bit words into M-bit words through
// two LCM-bit ping-pong banks, MSB-first. A packet start that lands mid-group
// replicates itself into the remaining slots, then opens the next group.
module axis_width_conv
    import axis_width_conv_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int M   = DEF_M,
    parameter int LCM = DEF_LCM
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] s_axis_tdata,
    input  logic         s_axis_tfirst,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tnext,
    output logic [M-1:0] m_axis_tdata,
    output logic         m_axis_tfirst,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tnext
);

    localparam int K_IN  = slots(LCM, N);
    localparam int K_OUT = slots(LCM, M);
    localparam int IW    = idx_width(K_IN);
    localparam int OW    = idx_width(K_OUT);
    localparam int BW    = idx_width(LCM);

    // A group width that does not hold a whole number of either word size
    // cannot be regrouped; refuse to build.
    if (!is_multiple(LCM, N) || !is_multiple(LCM, M)) begin : g_bad_geometry
        $error("axis_width_conv: LCM=%0d must be a common multiple of N=%0d and M=%0d",
               LCM, N, M);
    end

    // Bank storage and bookkeeping.
    logic [LCM-1:0] r_bank [2];
    logic [1:0]     r_full;
    logic [1:0]     r_tfirst;
    bank_e          r_fill_ptr;
    bank_e          r_drain_ptr;
    logic [IW-1:0]  r_idx;
    logic [OW-1:0]  r_odx;

    // Fill-side decode.
    logic          w_fill_ok;
    logic          w_pad;
    logic          w_first_slot;
    logic          w_last_slot;
    logic [BW-1:0] w_wr_base;

    // Drain-side decode.
    logic          w_drain_valid;
    logic          w_xfer;
    logic          w_last_slice;
    logic [BW-1:0] w_rd_base;

    // A slot can be written whenever the current fill bank has room. A packet
    // start arriving past slot 0 is written as padding but left pending, so
    // the same word later lands in slot 0 of a fresh group.
    assign w_fill_ok    = rst & s_axis_tvalid & ~r_full[r_fill_ptr];
    assign w_first_slot = (r_idx == IW'(0));
    assign w_pad        = ~w_first_slot & s_axis_tfirst;
    assign w_last_slot  = (r_idx == IW'(K_IN - 1));
    assign s_axis_tnext = w_fill_ok & ~w_pad;

    // Slot idx occupies bits [LCM-1-idx*N -: N]; expressed as an LSB offset.
    assign w_wr_base = BW'(LCM - N - (int'(r_idx) * N));

    // The drain bank presents a word whenever it holds a complete group.
    assign w_drain_valid = r_full[r_drain_ptr];
    assign w_xfer        = w_drain_valid & m_axis_tnext;
    assign w_last_slice  = (r_odx == OW'(K_OUT - 1));
    assign w_rd_base     = BW'(LCM - M - (int'(r_odx) * M));

    // Bank fill, bank drain and pointer advance; reset discards every group.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bank[0]   <= '0;
            r_bank[1]   <= '0;
            r_full      <= 2'b00;
            r_tfirst    <= 2'b00;
            r_fill_ptr  <= BANK_A;
            r_drain_ptr <= BANK_A;
            r_idx       <= '0;
            r_odx       <= '0;
        end else begin
            if (w_fill_ok) begin
                r_bank[r_fill_ptr][w_wr_base +: N] <= s_axis_tdata;
                if (w_first_slot) begin
                    r_tfirst[r_fill_ptr] <= s_axis_tfirst;
                end else begin
                    r_tfirst[r_fill_ptr] <= r_tfirst[r_fill_ptr];
                end
                if (w_last_slot) begin
                    r_full[r_fill_ptr] <= 1'b1;
                    r_idx              <= '0;
                    r_fill_ptr         <= other_bank(r_fill_ptr);
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end else begin
                r_idx <= r_idx;
            end

            // Fill and drain never target the same bank: fill needs a
            // not-full bank, drain needs a full one.
            if (w_xfer) begin
                if (w_last_slice) begin
                    r_full[r_drain_ptr] <= 1'b0;
                    r_odx               <= '0;
                    r_drain_ptr         <= other_bank(r_drain_ptr);
                end else begin
                    r_odx <= r_odx + OW'(1);
                end
            end else begin
                r_odx <= r_odx;
            end
        end
    end

    // Output slice select straight from bank state; zero when nothing is held.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tfirst = 1'b0;
        if (w_drain_valid) begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = r_bank[r_drain_ptr][w_rd_base +: M];
            m_axis_tfirst = r_tfirst[r_drain_ptr] & (r_odx == OW'(0));
        end else begin
            m_axis_tvalid = 1'b0;
            m_axis_tdata  = '0;
            m_axis_tfirst = 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_width_conv.sv
// tb_axis_width_conv: scoreboard bench for axis_width_conv. Three instances
// cover the default geometry (8->5/40) and the alternates (5->8/40, 8->8/8);
// one stream task drives whichever instance a test selects.
module tb_axis_width_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] s_tdata_a  [3];
    logic       s_tfirst_a [3];
    logic       s_tvalid_a [3];
    logic       m_tnext_a  [3];
    wire  [7:0] m_tdata_a  [3];
    wire        m_tfirst_a [3];
    wire        m_tvalid_a [3];
    wire        s_tnext_a  [3];

    int nw [3] = '{8, 5, 8};
    int mw [3] = '{5, 8, 8};
    int lw [3] = '{40, 40, 8};

    int errors = 0;
    int checks = 0;

    logic [8:0]  exp_q [$];
    logic [8:0]  in_q  [$];
    logic [63:0] mg;
    int          mi;
    bit          mtf;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int NK = (k == 1) ? 5 : 8;
        localparam int MK = (k == 0) ? 5 : 8;
        localparam int LK = (k == 2) ? 8 : 40;
        wire [MK-1:0] w_md;
        axis_width_conv #(.N(NK), .M(MK), .LCM(LK)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .s_axis_tdata  (s_tdata_a[k][NK-1:0]),
            .s_axis_tfirst (s_tfirst_a[k]),
            .s_axis_tvalid (s_tvalid_a[k]),
            .s_axis_tnext  (s_tnext_a[k]),
            .m_axis_tdata  (w_md),
            .m_axis_tfirst (m_tfirst_a[k]),
            .m_axis_tvalid (m_tvalid_a[k]),
            .m_axis_tnext  (m_tnext_a[k])
        );
        assign m_tdata_a[k] = 8'(w_md);
    end

    function automatic void model_reset();
        mg  = '0;
        mi  = 0;
        mtf = 1'b0;
    endfunction

    function automatic void model_put(input int inst, input int slot, input logic [8:0] w);
        for (int b = 0; b < nw[inst]; b++)
            mg[lw[inst] - 1 - slot * nw[inst] - b] = w[nw[inst] - 1 - b];
    endfunction

    function automatic void model_emit(input int inst);
        logic [7:0] val;
        for (int s = 0; s < lw[inst] / mw[inst]; s++) begin
            val = 8'h00;
            for (int b = 0; b < mw[inst]; b++)
                val = {val[6:0], mg[lw[inst] - 1 - s * mw[inst] - b]};
            exp_q.push_back({(mtf && s == 0), val});
        end
    endfunction

    // Stream-level reference: MSB-first packing, packet start pads the group.
    function automatic void model_word(input int inst, input logic [8:0] w);
        int kin;
        kin = lw[inst] / nw[inst];
        if (mi > 0 && w[8]) begin
            for (int s = mi; s < kin; s++) model_put(inst, s, w);
            model_emit(inst);
            mi = 0;
        end
        if (mi == 0) mtf = w[8];
        model_put(inst, mi, w);
        mi++;
        if (mi == kin) begin
            model_emit(inst);
            mi = 0;
        end
    endfunction

    function automatic logic [8:0] rand_word(input int inst);
        logic [7:0] mask;
        logic [7:0] d;
        mask = 8'((1 << nw[inst]) - 1);
        d    = 8'($urandom) & mask;
        return {($urandom_range(10) == 0), d};
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            s_tdata_a[i]  = 8'h00;
            s_tfirst_a[i] = 1'b0;
            s_tvalid_a[i] = 1'b0;
            m_tnext_a[i]  = 1'b0;
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        exp_q.delete();
        in_q.delete();
    endtask

    // Drives in_q into instance inst and scores every accepted output word.
    task automatic run_stream(input int inst, input int gap_pct, input int stall_pct,
                              input bit use_model);
        logic [8:0] pend;
        logic [8:0] e;
        logic [7:0] prev_d;
        logic       prev_f;
        bit         have, prev_stall, took, xfer;
        int         total, consumed, idle, bad_next, extra;
        pend = '0; have = 1'b0; prev_stall = 1'b0; prev_d = 8'h00; prev_f = 1'b0;
        total = in_q.size(); consumed = 0; idle = 0; bad_next = 0; extra = 0;
        while ((consumed < total || exp_q.size() > 0) && idle <= 1000) begin
            if (!have && in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                pend = in_q.pop_front();
                have = 1'b1;
                if (use_model) model_word(inst, pend);
            end
            s_tvalid_a[inst] = have;
            s_tdata_a[inst]  = have ? pend[7:0] : 8'h00;
            s_tfirst_a[inst] = have & pend[8];
            m_tnext_a[inst]  = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (!have && s_tnext_a[inst]) bad_next++;
            if (prev_stall) begin
                checks++;
                if (m_tvalid_a[inst] !== 1'b1 || m_tdata_a[inst] !== prev_d ||
                    m_tfirst_a[inst] !== prev_f) begin
                    errors++;
                    $display("FAIL hold_stable[%0d]: valid=%0b data=%02h tfirst=%0b, required valid=1 data=%02h tfirst=%0b",
                             inst, m_tvalid_a[inst], m_tdata_a[inst], m_tfirst_a[inst], prev_d, prev_f);
                end
            end
            xfer = m_tvalid_a[inst] && m_tnext_a[inst];
            if (xfer) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out[%0d]: got tfirst=%0b data=%02h, required no output",
                             inst, m_tfirst_a[inst], m_tdata_a[inst]);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tfirst_a[inst], m_tdata_a[inst]} !== e) begin
                        errors++;
                        $display("FAIL out_word[%0d]: got tfirst=%0b data=%02h, required tfirst=%0b data=%02h",
                                 inst, m_tfirst_a[inst], m_tdata_a[inst], e[8], e[7:0]);
                    end
                end
            end
            took       = have && s_tnext_a[inst];
            prev_stall = m_tvalid_a[inst] && !m_tnext_a[inst];
            prev_d     = m_tdata_a[inst];
            prev_f     = m_tfirst_a[inst];
            idle       = (took || xfer) ? 0 : idle + 1;
            @(posedge clk);
            #1;
            if (took) begin
                have = 1'b0;
                consumed++;
            end
        end
        checks++;
        if (idle > 1000) begin
            errors++;
            $display("FAIL stall_timeout[%0d]: %0d idle cycles, %0d words pending out, required progress",
                     inst, idle, exp_q.size());
        end
        checks++;
        if (consumed != total) begin
            errors++;
            $display("FAIL consumed[%0d]: got %0d words read, required %0d", inst, consumed, total);
        end
        checks++;
        if (bad_next != 0) begin
            errors++;
            $display("FAIL tnext_idle[%0d]: tnext high %0d times without tvalid, required 0", inst, bad_next);
        end
        s_tvalid_a[inst] = 1'b0;
        s_tfirst_a[inst] = 1'b0;
        s_tdata_a[inst]  = 8'h00;
        m_tnext_a[inst]  = 1'b1;
        repeat (18) begin
            @(negedge clk);
            if (m_tvalid_a[inst]) extra++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL extra_output[%0d]: got %0d extra words, required 0", inst, extra);
        end
        m_tnext_a[inst] = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst           = 1'b0;
        s_tvalid_a[0] = 1'b1;
        s_tdata_a[0]  = 8'hA5;
        s_tfirst_a[0] = 1'b1;
        m_tnext_a[0]  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_tvalid_a[0] !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", m_tvalid_a[0]); end
        checks++;
        if (m_tdata_a[0] !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, required 00", m_tdata_a[0]); end
        checks++;
        if (m_tfirst_a[0] !== 1'b0) begin errors++; $display("FAIL reset_tfirst: got %0b, required 0", m_tfirst_a[0]); end
        checks++;
        if (s_tnext_a[0] !== 1'b0) begin errors++; $display("FAIL reset_tnext: got %0b, required 0", s_tnext_a[0]); end
    endtask

    task automatic test_convert();
        apply_reset();
        in_q  = '{9'h112, 9'h034, 9'h056, 9'h078, 9'h09A};
        exp_q = '{9'h102, 9'h008, 9'h01A, 9'h005, 9'h00C, 9'h01E, 9'h004, 9'h01A};
        run_stream(0, 0, 0, 1'b0);
    endtask

    task automatic test_pad();
        apply_reset();
        in_q  = '{9'h111, 9'h022, 9'h1FF, 9'h001, 9'h002, 9'h003, 9'h004};
        exp_q = '{9'h102, 9'h004, 9'h011, 9'h00F, 9'h01F, 9'h01F, 9'h01F, 9'h01F,
                  9'h11F, 9'h01C, 9'h000, 9'h010, 9'h004, 9'h000, 9'h018, 9'h004};
        run_stream(0, 0, 0, 1'b0);
    endtask

    task automatic test_back_pressure();
        apply_reset();
        for (int i = 0; i < 60; i++) in_q.push_back(rand_word(0));
        run_stream(0, 0, 50, 1'b1);
    endtask

    // Fill both banks with the consumer stalled: latency and input blocking.
    task automatic test_both_full();
        logic [8:0] w;
        apply_reset();
        m_tnext_a[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w    = rand_word(0);
            w[8] = (i == 0 || i == 5);
            model_word(0, w);
            s_tvalid_a[0] = 1'b1;
            s_tdata_a[0]  = w[7:0];
            s_tfirst_a[0] = w[8];
            @(negedge clk);
            checks++;
            if (s_tnext_a[0] !== 1'b1) begin errors++; $display("FAIL fill_tnext: word %0d got %0b, required 1", i, s_tnext_a[0]); end
            if (i == 4) begin
                checks++;
                if (m_tvalid_a[0] !== 1'b0) begin errors++; $display("FAIL latency_early: got valid=%0b, required 0", m_tvalid_a[0]); end
            end
            if (i == 5) begin
                checks++;
                if (m_tvalid_a[0] !== 1'b1 || m_tfirst_a[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_rise: got valid=%0b tfirst=%0b, required valid=1 tfirst=1", m_tvalid_a[0], m_tfirst_a[0]);
                end
            end
            @(posedge clk);
            #1;
        end
        w    = rand_word(0);
        w[8] = 1'b0;
        s_tdata_a[0]  = w[7:0];
        s_tfirst_a[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_tnext_a[0] !== 1'b0) begin errors++; $display("FAIL full_block: got tnext=%0b, required 0", s_tnext_a[0]); end
            @(posedge clk);
            #1;
        end
        in_q.push_back(w);
        for (int i = 0; i < 4; i++) in_q.push_back({1'b0, 8'($urandom)});
        run_stream(0, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 1024; i++) in_q.push_back(rand_word(0));
        run_stream(0, 25, 30, 1'b1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_tnext_a[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_tvalid_a[0] = 1'b1;
            s_tdata_a[0]  = 8'($urandom);
            s_tfirst_a[0] = (i == 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (m_tvalid_a[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %0b, required 1", m_tvalid_a[0]); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_tvalid_a[0], m_tfirst_a[0], m_tdata_a[0]} !== 10'h000) begin
            errors++;
            $display("FAIL midreset_out: got valid=%0b tfirst=%0b data=%02h, required all 0",
                     m_tvalid_a[0], m_tfirst_a[0], m_tdata_a[0]);
        end
        checks++;
        if (s_tnext_a[0] !== 1'b0) begin errors++; $display("FAIL midreset_tnext: got %0b, required 0", s_tnext_a[0]); end
        s_tvalid_a[0] = 1'b0;
        rst           = 1'b1;
        model_reset();
        exp_q.delete();
        in_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 40; i++) in_q.push_back(rand_word(0));
        run_stream(0, 10, 20, 1'b1);
    endtask

    task automatic test_alt_params();
        for (int inst = 1; inst < 3; inst++) begin
            apply_reset();
            for (int i = 0; i < 200; i++) in_q.push_back(rand_word(inst));
            run_stream(inst, 20, 30, 1'b1);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_convert();
        test_pad();
        test_back_pressure();
        test_both_full();
        test_random();
        test_reset_mid();
        test_alt_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
